dly_line: RTL and testbench

- Parametrised delay line: WIDTH-bit data plus valid flag, delayed by a runtime-programmable 0..DEPTH clock cycles.
- Successor to the single-bit latch/flop primitives used in the delay-modelling chapter.
- Delay 0 gives latch-like transparency; delay k≥1 is a k-stage register pipeline.
- Advance enable (stall), flush-on-reprogram, fill tracking and a sticky range-error flag.

---
 rtl/dly_line_pkg.sv | 28 ++
 rtl/dly_line_if.sv | 28 ++
 rtl/dly_line_stage.sv | 32 +++
 rtl/dly_line.sv | 134 +++++++++++++
 tb/tb_dly_line.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/dly_line_pkg.sv
// Shared types and helpers for the programmable delay line.
package dly_line_pkg;

    // Default stage payload width; the top re-declares the record at its own WIDTH.
    localparam int unsigned STG_W_DEF = 8;

    // One pipeline stage: payload plus its qualifier.
    typedef struct packed {
        logic [STG_W_DEF-1:0] data;
        logic                 vld;
    } stg_rec_t;

    // Result of clamping a requested delay against the pipeline depth.
    typedef struct packed {
        logic [31:0] val;
        logic        ovf;
    } dly_clamp_t;

    // Limit a requested delay to the available depth and flag the overflow.
    function automatic dly_clamp_t clamp_dly(input logic [31:0] dly,
                                             input logic [31:0] depth);
        dly_clamp_t r;
        r.ovf = (dly > depth);
        r.val = r.ovf ? depth : dly;
        return r;
    endfunction

endpackage

// File: rtl/dly_line_if.sv
// Data, control and status bundle of the delay line.
interface dly_line_if #(
    parameter int WIDTH = 8,
    parameter int DLY_W = 5
);
    logic             en;
    logic [WIDTH-1:0] d;
    logic             d_vld;
    logic [DLY_W-1:0] dly;
    logic             dly_ld;
    logic [WIDTH-1:0] q;
    logic             q_vld;
    logic             primed;
    logic             dly_err;

    // Producer / controller side.
    modport master (
        output en, d, d_vld, dly, dly_ld,
        input  q, q_vld, primed, dly_err
    );

    // Delay line side.
    modport slave (
        input  en, d, d_vld, dly, dly_ld,
        output q, q_vld, primed, dly_err
    );

endinterface

// File: rtl/dly_line_stage.sv
// Single enable-gated data+valid register with flush of the valid bit.
// Shift wins over flush: when both are asserted the stage takes rec_i, and
// the caller is expected to have already masked the incoming valid.
module dly_stage
    import dly_line_pkg::*;
#(
    parameter type rec_t = stg_rec_t
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic flush_i,
    input  rec_t rec_i,
    output rec_t rec_o
);

    rec_t rec_q;

    // Capture on advance; otherwise a flush drops only the valid, data is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            rec_q <= '0;
        end else if (en_i) begin
            rec_q <= rec_i;
        end else if (flush_i) begin
            rec_q.vld <= 1'b0;
        end
    end

    assign rec_o = rec_q;

endmodule

// File: rtl/dly_line.sv
// Runtime-programmable delay line: 0..DEPTH cycles of data+valid delay.
// Delay 0 is transparent while advancing and latched while stalled; delay k
// taps stage k-1 of a shift pipeline. Reprogramming flushes all valids and
// restarts fill tracking.
module dly_line
    import dly_line_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int DLY_INIT = 1
) (
    input  logic     clk,
    input  logic     rst,
    dly_line_if.slave bus
);

    localparam int DLY_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             vld;
    } stg_t;

    stg_t stg_in  [DEPTH];
    stg_t stg_out [DEPTH];
    stg_t hold_in;
    stg_t hold_out;

    logic [DLY_W-1:0] dly_r_q, dly_r_d;
    logic [DLY_W-1:0] fill_q,  fill_d;
    logic             err_q,   err_d;
    dly_clamp_t       clamp;

    logic [WIDTH-1:0] q_sel;
    logic             vld_sel;

    // Stage inputs: stage 0 takes the new sample; downstream valids are masked
    // on a load so that a load+advance edge leaves only stage 0 valid.
    always_comb begin
        stg_in[0].data = bus.d;
        stg_in[0].vld  = bus.d_vld;
        for (int i = 1; i < DEPTH; i++) begin
            stg_in[i].data = stg_out[i-1].data;
            stg_in[i].vld  = stg_out[i-1].vld & ~bus.dly_ld;
        end
    end

    // Shift pipeline.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stg
        dly_stage #(.rec_t(stg_t)) u_stg (
            .clk     (clk),
            .rst     (rst),
            .en_i    (bus.en),
            .flush_i (bus.dly_ld),
            .rec_i   (stg_in[gi]),
            .rec_o   (stg_out[gi])
        );
    end

    // Hold register feeding the latched side of the zero-delay path.
    always_comb begin
        hold_in.data = bus.d;
        hold_in.vld  = bus.d_vld;
    end

    dly_stage #(.rec_t(stg_t)) u_hold (
        .clk     (clk),
        .rst     (rst),
        .en_i    (bus.en),
        .flush_i (bus.dly_ld),
        .rec_i   (hold_in),
        .rec_o   (hold_out)
    );

    // Clamp the requested delay against the physical depth.
    always_comb begin
        clamp = clamp_dly(32'(bus.dly), 32'(DEPTH));
    end

    // Next-state for delay select, fill counter and sticky range error.
    always_comb begin
        dly_r_d = dly_r_q;
        fill_d  = fill_q;
        err_d   = err_q;
        if (bus.dly_ld) begin
            dly_r_d = DLY_W'(clamp.val);
            err_d   = err_q | clamp.ovf;
            fill_d  = bus.en ? DLY_W'(1) : '0;
        end else if (bus.en && (fill_q < dly_r_q)) begin
            fill_d = fill_q + 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            dly_r_q <= DLY_W'(DLY_INIT);
            fill_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            dly_r_q <= dly_r_d;
            fill_q  <= fill_d;
            err_q   <= err_d;
        end
    end

    // Output tap select; delay 0 bypasses the pipeline entirely.
    always_comb begin
        q_sel   = '0;
        vld_sel = 1'b0;
        if (dly_r_q == '0) begin
            if (bus.en) begin
                q_sel   = bus.d;
                vld_sel = bus.d_vld;
            end else begin
                q_sel   = hold_out.data;
                vld_sel = hold_out.vld;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (dly_r_q == DLY_W'(i + 1)) begin
                    q_sel   = stg_out[i].data;
                    vld_sel = stg_out[i].vld;
                end
            end
        end
    end

    assign bus.q       = q_sel;
    assign bus.q_vld   = vld_sel;
    assign bus.primed  = (fill_q >= dly_r_q);
    assign bus.dly_err = err_q;

endmodule

// File: tb/tb_dly_line.sv
// Directed bench for the programmable delay line.
module tb_dly_line;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int DLY_W = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dly_line_if #(.WIDTH(WIDTH), .DLY_W(DLY_W)) bus1 ();
    dly_line_if #(.WIDTH(WIDTH), .DLY_W(DLY_W)) bus0 ();

    dly_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DLY_INIT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    dly_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DLY_INIT(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [7:0] d, input logic v);
        bus1.en    = en;
        bus1.d     = d;
        bus1.d_vld = v;
    endtask

    logic [7:0] held;
    logic       held_vld;
    logic       en_t;
    logic       stall;
    int         n_en;
    int         smp;

    initial begin
        rst         = 1'b1;
        bus1.en     = 1'b0;
        bus1.d      = '0;
        bus1.d_vld  = 1'b0;
        bus1.dly    = '0;
        bus1.dly_ld = 1'b0;
        bus0.en     = 1'b0;
        bus0.d      = '0;
        bus0.d_vld  = 1'b0;
        bus0.dly    = '0;
        bus0.dly_ld = 1'b0;
        tick();
        tick();

        // Reset state for both initial delays
        chk("rst_q",       32'(bus1.q), 0);
        chk("rst_q_vld",   32'(bus1.q_vld), 0);
        chk("rst_dly_err", 32'(bus1.dly_err), 0);
        chk("rst_primed1", 32'(bus1.primed), 0);
        chk("rst_primed0", 32'(bus0.primed), 1);
        chk("rst_q0",      32'(bus0.q), 0);
        chk("rst_q_vld0",  32'(bus0.q_vld), 0);
        rst = 1'b0;

        // Fixed delay 3, continuous stream
        bus1.dly    = 5'd3;
        bus1.dly_ld = 1'b1;
        tick();
        bus1.dly_ld = 1'b0;
        chk("d3_primed_start", 32'(bus1.primed), 0);
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 8'(k), 1'b1);
            tick();
            chk("d3_q_vld",  32'(bus1.q_vld),  32'(k >= 3));
            chk("d3_primed", 32'(bus1.primed), 32'(k >= 3));
            if (k >= 3) chk("d3_q", 32'(bus1.q), 32'(k - 2));
        end
        drive(1'b0, 8'h00, 1'b0);

        // Delay 0: transparent while advancing, latched while stalled
        bus1.dly    = 5'd0;
        bus1.dly_ld = 1'b1;
        tick();
        bus1.dly_ld = 1'b0;
        chk("d0_primed", 32'(bus1.primed), 1);
        held     = 8'h00;
        held_vld = 1'b0;
        for (int t = 0; t < 12; t++) begin
            en_t = ((t / 3) % 2 == 0);
            drive(en_t, 8'(8'h40 + t), 1'b1);
            #1;
            if (en_t) begin
                chk("d0_q_pass",     32'(bus1.q),     32'(8'h40 + t));
                chk("d0_q_vld_pass", 32'(bus1.q_vld), 1);
                held     = 8'(8'h40 + t);
                held_vld = 1'b1;
            end else begin
                chk("d0_q_hold",     32'(bus1.q),     32'(held));
                chk("d0_q_vld_hold", 32'(bus1.q_vld), 32'(held_vld));
            end
            tick();
        end
        drive(1'b0, 8'h00, 1'b0);

        // Delay 4 with a 5-cycle stall after the sixth sample
        bus1.dly    = 5'd4;
        bus1.dly_ld = 1'b1;
        tick();
        bus1.dly_ld = 1'b0;
        chk("d4_q_vld_start", 32'(bus1.q_vld), 0);
        n_en = 0;
        smp  = 0;
        for (int s = 0; s < 17; s++) begin
            stall = (s >= 6) && (s <= 10);
            if (stall) begin
                drive(1'b0, 8'hEE, 1'b0);
            end else begin
                drive(1'b1, 8'(8'h80 + smp), 1'b1);
                smp++;
            end
            tick();
            if (!stall) n_en++;
            chk("d4_q_vld",  32'(bus1.q_vld),  32'(n_en >= 4));
            chk("d4_primed", 32'(bus1.primed), 32'(n_en >= 4));
            if (n_en >= 4) chk("d4_q", 32'(bus1.q), 32'(8'h80 + n_en - 4));
        end

        // Reprogram 4 -> 2 with load and advance on the same edge
        for (int j = 0; j < 6; j++) begin
            drive(1'b1, 8'(8'hA0 + j), 1'b1);
            tick();
        end
        drive(1'b1, 8'hA6, 1'b1);
        bus1.dly    = 5'd2;
        bus1.dly_ld = 1'b1;
        #1;
        chk("rp_pre_q",     32'(bus1.q),     32'h00A2);
        chk("rp_pre_q_vld", 32'(bus1.q_vld), 1);
        tick();
        bus1.dly_ld = 1'b0;
        chk("rp_flush_q_vld",  32'(bus1.q_vld),  0);
        chk("rp_flush_primed", 32'(bus1.primed), 0);
        drive(1'b1, 8'hA7, 1'b1);
        tick();
        chk("rp_emerge_q",      32'(bus1.q),      32'h00A6);
        chk("rp_emerge_q_vld",  32'(bus1.q_vld),  1);
        chk("rp_emerge_primed", 32'(bus1.primed), 1);
        drive(1'b1, 8'hA8, 1'b1);
        bus1.dly = 5'd7;
        tick();
        chk("rp_ignore_dly_q1", 32'(bus1.q), 32'h00A7);
        drive(1'b1, 8'hA9, 1'b1);
        tick();
        chk("rp_ignore_dly_q2", 32'(bus1.q), 32'h00A8);
        drive(1'b0, 8'h00, 1'b0);

        // Out-of-range load clamps to DEPTH and sets the sticky error
        chk("err_before", 32'(bus1.dly_err), 0);
        bus1.dly    = 5'd17;
        bus1.dly_ld = 1'b1;
        tick();
        bus1.dly_ld = 1'b0;
        chk("err_set",        32'(bus1.dly_err), 1);
        chk("err_primed_off", 32'(bus1.primed),  0);
        for (int k = 1; k <= 16; k++) begin
            drive(1'b1, 8'(8'hC0 + k - 1), 1'b1);
            tick();
            if (k == 15) begin
                chk("clamp_primed_15", 32'(bus1.primed), 0);
                chk("clamp_q_vld_15",  32'(bus1.q_vld),  0);
            end
            if (k == 16) begin
                chk("clamp_primed_16", 32'(bus1.primed), 1);
                chk("clamp_q_vld_16",  32'(bus1.q_vld),  1);
                chk("clamp_q_16",      32'(bus1.q),      32'h00C0);
            end
        end
        drive(1'b0, 8'h00, 1'b0);
        bus1.dly    = 5'd2;
        bus1.dly_ld = 1'b1;
        tick();
        bus1.dly_ld = 1'b0;
        chk("err_sticky", 32'(bus1.dly_err), 1);

        // Reset in the middle of a stream
        drive(1'b1, 8'h31, 1'b1);
        tick();
        drive(1'b1, 8'h32, 1'b1);
        tick();
        chk("mid_q_vld_pre", 32'(bus1.q_vld), 1);
        chk("mid_q_pre",     32'(bus1.q),     32'h0031);
        rst = 1'b1;
        drive(1'b1, 8'h33, 1'b1);
        tick();
        chk("mid_rst_q",       32'(bus1.q),       0);
        chk("mid_rst_q_vld",   32'(bus1.q_vld),   0);
        chk("mid_rst_dly_err", 32'(bus1.dly_err), 0);
        chk("mid_rst_primed",  32'(bus1.primed),  0);
        rst = 1'b0;
        drive(1'b1, 8'h5A, 1'b1);
        tick();
        chk("post_rst_q",      32'(bus1.q),      32'h005A);
        chk("post_rst_q_vld",  32'(bus1.q_vld),  1);
        chk("post_rst_primed", 32'(bus1.primed), 1);
        drive(1'b0, 8'h00, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
